mig1_jtag_tap: RTL and testbench

JTAG TAP controller and debug-bus master for the Mig1 CPU. It oversamples the external `tck`/`tms`/`tdi`/`trst` pins in the core `clk` domain and runs the IEEE 1149.1 16-state TAP FSM. It decodes a 4-bit IR and turns DR scans into word-addressed debug read/write requests on a simple req/ack bus into the core. It sits inside `Mig1CPU` between the JTAG pins and the core's debug port.

---
 rtl/mig1_jtag_pkg.sv | 56 +++++
 rtl/mig1_jtag_sync.sv | 48 ++++
 rtl/mig1_jtag_tap.sv | 170 +++++++++++++++++
 tb/tb_mig1_jtag_tap.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mig1_jtag_pkg.sv
// Shared types for the Mig1 JTAG TAP: 1149.1 state encoding, IR opcodes
// and the TAP next-state rule.
package mig1_jtag_pkg;

   localparam int IR_W = 4;

   localparam logic [IR_W-1:0] IR_IDCODE   = 4'b0001;
   localparam logic [IR_W-1:0] IR_DBG_ADDR = 4'b0010;
   localparam logic [IR_W-1:0] IR_DBG_DATA = 4'b0011;
   localparam logic [IR_W-1:0] IR_BYPASS   = 4'b1111;

   typedef enum logic [3:0] {
      TLR      = 4'd0,
      RTI      = 4'd1,
      SEL_DR   = 4'd2,
      CAP_DR   = 4'd3,
      SHIFT_DR = 4'd4,
      EXIT1_DR = 4'd5,
      PAUSE_DR = 4'd6,
      EXIT2_DR = 4'd7,
      UPD_DR   = 4'd8,
      SEL_IR   = 4'd9,
      CAP_IR   = 4'd10,
      SHIFT_IR = 4'd11,
      EXIT1_IR = 4'd12,
      PAUSE_IR = 4'd13,
      EXIT2_IR = 4'd14,
      UPD_IR   = 4'd15
   } tap_state_t;

   // 1149.1 state diagram, evaluated on a tck rise with the sampled tms.
   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      tap_state_t n;
      case (s)
         TLR:      n = tms ? TLR      : RTI;
         RTI:      n = tms ? SEL_DR   : RTI;
         SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   n = tms ? SEL_DR   : RTI;
         SEL_IR:   n = tms ? TLR      : CAP_IR;
         CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   n = tms ? SEL_DR   : RTI;
         default:  n = TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mig1_jtag_sync.sv
// Brings the asynchronous JTAG pins into the clk domain and turns tck
// edges into single-cycle rise/fall strobes.
module mig1_jtag_sync (
   input  logic clk,
   input  logic rst,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   input  logic trst,
   output logic tms_sync,
   output logic tdi_sync,
   output logic trst_sync,
   output logic tck_rise,
   output logic tck_fall
);

   logic [1:0] tck_q_r;
   logic [1:0] tms_q_r;
   logic [1:0] tdi_q_r;
   logic [1:0] trst_q_r;
   logic       tck_d_r;

   // Two-flop synchronizers plus a registered edge detector on tck.
   always_ff @(posedge clk) begin
      if (rst) begin
         tck_q_r  <= 2'b00;
         tms_q_r  <= 2'b00;
         tdi_q_r  <= 2'b00;
         trst_q_r <= 2'b00;
         tck_d_r  <= 1'b0;
         tck_rise <= 1'b0;
         tck_fall <= 1'b0;
      end else begin
         tck_q_r  <= {tck_q_r[0], tck};
         tms_q_r  <= {tms_q_r[0], tms};
         tdi_q_r  <= {tdi_q_r[0], tdi};
         trst_q_r <= {trst_q_r[0], trst};
         tck_d_r  <= tck_q_r[1];
         tck_rise <= tck_q_r[1] & ~tck_d_r;
         tck_fall <= ~tck_q_r[1] & tck_d_r;
      end
   end

   assign tms_sync  = tms_q_r[1];
   assign tdi_sync  = tdi_q_r[1];
   assign trst_sync = trst_q_r[1];

endmodule

// File: rtl/mig1_jtag_tap.sv
// JTAG TAP controller and debug-bus master for Mig1: oversampled TAP FSM,
// 4-bit IR and DR scans mapped onto word-addressed req/ack bus requests.
module mig1_jtag_tap
   import mig1_jtag_pkg::*;
#(
   parameter logic [31:0] IDCODE = 32'h1000_0CA1,
   parameter int          ADDR_W = 14,
   parameter int          DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tck,
   input  logic              tms,
   input  logic              tdi,
   input  logic              trst,
   output logic              tdo,
   output logic              dbg_req,
   output logic              dbg_we,
   output logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_ack,
   input  logic [DATA_W-1:0] dbg_rdata
);

   logic tms_sync_s;
   logic tdi_sync_s;
   logic trst_sync_s;
   logic tck_rise_s;
   logic tck_fall_s;

   tap_state_t        state_r;
   tap_state_t        next_state_s;
   logic [IR_W-1:0]   ir_r;
   logic [IR_W-1:0]   ir_sr_r;
   logic [31:0]       id_sr_r;
   logic [ADDR_W-1:0] addr_sr_r;
   logic [DATA_W:0]   data_sr_r;
   logic              byp_sr_r;
   logic              upd_dr_r;
   logic              dr_lsb_s;

   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_inc_s;
   logic [DATA_W-1:0] rdata_hold_r;
   logic              busy_s;
   logic              ack_s;

   mig1_jtag_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .tck       (tck),
      .tms       (tms),
      .tdi       (tdi),
      .trst      (trst),
      .tms_sync  (tms_sync_s),
      .tdi_sync  (tdi_sync_s),
      .trst_sync (trst_sync_s),
      .tck_rise  (tck_rise_s),
      .tck_fall  (tck_fall_s)
   );

   assign next_state_s = tap_next(state_r, tms_sync_s);

   // A request outstanding on the bus is exactly the busy condition.
   assign busy_s     = dbg_req;
   assign ack_s      = dbg_req & dbg_ack;
   assign addr_inc_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};

   // LSB of the DR selected by the current instruction; unknown opcodes act as BYPASS.
   always_comb begin
      dr_lsb_s = byp_sr_r;
      case (ir_r)
         IR_IDCODE:   dr_lsb_s = id_sr_r[0];
         IR_DBG_ADDR: dr_lsb_s = addr_sr_r[0];
         IR_DBG_DATA: dr_lsb_s = data_sr_r[0];
         IR_BYPASS:   dr_lsb_s = byp_sr_r;
         default:     dr_lsb_s = byp_sr_r;
      endcase
   end

   // TAP FSM, IR and DR shift registers, and tdo launch on tck falls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= TLR;
         ir_r      <= IR_IDCODE;
         ir_sr_r   <= {IR_W{1'b0}};
         id_sr_r   <= 32'h0000_0000;
         addr_sr_r <= {ADDR_W{1'b0}};
         data_sr_r <= {(DATA_W+1){1'b0}};
         byp_sr_r  <= 1'b0;
         upd_dr_r  <= 1'b0;
         tdo       <= 1'b0;
      end else if (trst_sync_s) begin
         state_r  <= TLR;
         ir_r     <= IR_IDCODE;
         upd_dr_r <= 1'b0;
      end else begin
         upd_dr_r <= 1'b0;
         if (state_r == TLR) begin
            ir_r <= IR_IDCODE;
         end
         if (tck_rise_s) begin
            state_r  <= next_state_s;
            upd_dr_r <= (next_state_s == UPD_DR);
            case (state_r)
               CAP_IR:   ir_sr_r <= 4'b0001;
               SHIFT_IR: ir_sr_r <= {tdi_sync_s, ir_sr_r[IR_W-1:1]};
               CAP_DR: begin
                  case (ir_r)
                     IR_IDCODE:   id_sr_r   <= IDCODE;
                     IR_DBG_ADDR: addr_sr_r <= addr_r;
                     IR_DBG_DATA: data_sr_r <= {busy_s, rdata_hold_r};
                     default:     byp_sr_r  <= 1'b0;
                  endcase
               end
               SHIFT_DR: begin
                  case (ir_r)
                     IR_IDCODE:   id_sr_r   <= {tdi_sync_s, id_sr_r[31:1]};
                     IR_DBG_ADDR: addr_sr_r <= {tdi_sync_s, addr_sr_r[ADDR_W-1:1]};
                     IR_DBG_DATA: data_sr_r <= {tdi_sync_s, data_sr_r[DATA_W:1]};
                     default:     byp_sr_r  <= tdi_sync_s;
                  endcase
               end
               default: begin
               end
            endcase
            if (next_state_s == UPD_IR) begin
               ir_r <= ir_sr_r;
            end
         end
         if (tck_fall_s) begin
            case (state_r)
               SHIFT_IR: tdo <= ir_sr_r[0];
               SHIFT_DR: tdo <= dr_lsb_s;
               default:  tdo <= 1'b0;
            endcase
         end
      end
   end

   // Debug bus master: ack retires the outstanding request before a new Update-DR is considered.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_req      <= 1'b0;
         dbg_we       <= 1'b0;
         dbg_addr     <= {ADDR_W{1'b0}};
         dbg_wdata    <= {DATA_W{1'b0}};
         addr_r       <= {ADDR_W{1'b0}};
         rdata_hold_r <= {DATA_W{1'b0}};
      end else begin
         if (ack_s) begin
            dbg_req <= 1'b0;
            addr_r  <= addr_inc_s;
            if (!dbg_we) begin
               rdata_hold_r <= dbg_rdata;
            end
         end
         if (upd_dr_r && (ir_r == IR_DBG_ADDR)) begin
            addr_r <= addr_sr_r;
         end
         if (upd_dr_r && (ir_r == IR_DBG_DATA) && (!busy_s || ack_s)) begin
            dbg_req   <= 1'b1;
            dbg_we    <= data_sr_r[DATA_W];
            dbg_wdata <= data_sr_r[DATA_W-1:0];
            dbg_addr  <= ack_s ? addr_inc_s : addr_r;
         end
      end
   end

endmodule

// File: tb/tb_mig1_jtag_tap.sv
// Directed and randomized JTAG scans against a register-level model of the
// TAP's instruction/data registers and the debug bus request it should raise.
module tb_mig1_jtag_tap;

   localparam int          ADDR_W = 14;
   localparam int          DATA_W = 32;
   localparam logic [31:0] IDCODE = 32'h1000_0CA1;

   logic              clk = 1'b0;
   logic              rst, tck, tms, tdi, trst, tdo;
   logic              dbg_req, dbg_we, dbg_ack;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata, dbg_rdata;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [3:0]        m_ir;
   logic [ADDR_W-1:0] m_addr, m_req_addr;
   logic              m_busy, m_we;
   logic [DATA_W-1:0] m_rhold, m_wdata;

   always #5 clk = ~clk;

   mig1_jtag_tap dut (
      .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trst(trst),
      .tdo(tdo), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full tck period; tdo is sampled just before the rise (it was launched on the previous fall).
   task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
      tms   = tms_v;
      tdi   = tdi_v;
      tdo_v = tdo;
      tck   = 1'b1;
      repeat (6) @(negedge clk);
      tck   = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic go_rti();
      logic t;
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      m_ir = 4'b0001;
   endtask

   // From Run-Test/Idle: scan n bits through DR and return to Run-Test/Idle.
   task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
      logic t;
      dout = 64'd0;
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      for (int i = 0; i < n; i++) begin
         tck_cycle(i == n - 1, din[i], t);
         dout[i] = t;
      end
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
   endtask

   task automatic do_ir(input string tag, input logic [3:0] v);
      logic t;
      logic [3:0] got;
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      for (int i = 0; i < 4; i++) begin
         tck_cycle(i == 3, v[i], t);
         got[i] = t;
      end
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      check(tag, {60'd0, got}, 64'h1);
      m_ir = v;
   endtask

   function automatic int m_len();
      case (m_ir)
         4'b0001: return 32;
         4'b0010: return ADDR_W;
         4'b0011: return DATA_W + 1;
         default: return 1;
      endcase
   endfunction

   function automatic logic [63:0] m_cap();
      case (m_ir)
         4'b0001: return {32'd0, IDCODE};
         4'b0010: return {{(64-ADDR_W){1'b0}}, m_addr};
         4'b0011: return {31'd0, m_busy, m_rhold};
         default: return 64'd0;
      endcase
   endfunction

   // A length-len register captured with cap emits cap first, then the bits fed in.
   function automatic logic [63:0] expect_out(logic [63:0] cap, int len, int n, logic [63:0] din);
      logic [63:0] r = 64'd0;
      for (int i = 0; i < n; i++) begin
         if (i < len) r[i] = cap[i];
         else         r[i] = din[i-len];
      end
      return r;
   endfunction

   task automatic do_dr(input string tag, input int n, input logic [63:0] din);
      logic [63:0] got, exp;
      exp = expect_out(m_cap(), m_len(), n, din);
      scan_dr(n, din, got);
      check(tag, got, exp);
      if (m_ir == 4'b0010) begin
         m_addr = din[ADDR_W-1:0];
      end else if (m_ir == 4'b0011 && !m_busy) begin
         m_busy     = 1'b1;
         m_we       = din[DATA_W];
         m_wdata    = din[DATA_W-1:0];
         m_req_addr = m_addr;
      end
      check({tag, "_req"}, {63'd0, dbg_req}, {63'd0, m_busy});
      if (m_busy) begin
         check({tag, "_bus"}, {17'd0, dbg_we, dbg_addr, dbg_wdata}, {17'd0, m_we, m_req_addr, m_wdata});
      end
   endtask

   // Hold off the ack for a while, confirming the request stays put, then complete it.
   task automatic bus_ack(input int delay, input logic [DATA_W-1:0] rd);
      logic stable = 1'b1;
      repeat (delay) begin
         @(negedge clk);
         if ({dbg_req, dbg_we, dbg_addr, dbg_wdata} !== {1'b1, m_we, m_req_addr, m_wdata}) stable = 1'b0;
      end
      check("hold", {63'd0, stable}, 64'd1);
      dbg_ack   = 1'b1;
      dbg_rdata = rd;
      @(negedge clk);
      dbg_ack   = 1'b0;
      dbg_rdata = $urandom;
      @(negedge clk);
      check("ack_drop", {63'd0, dbg_req}, 64'd0);
      m_busy = 1'b0;
      if (!m_we) m_rhold = rd;
      m_addr = m_addr + 1'b1;
   endtask

   initial begin
      logic t;
      logic [31:0] r32;
      rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst = 1'b0;
      dbg_ack = 1'b0; dbg_rdata = 32'd0;
      m_ir = 4'b0001; m_addr = '0; m_req_addr = '0; m_busy = 1'b0;
      m_we = 1'b0; m_rhold = '0; m_wdata = '0;
      repeat (5) @(negedge clk);
      check("rst_tdo",   {63'd0, tdo}, 64'd0);
      check("rst_req",   {63'd0, dbg_req}, 64'd0);
      check("rst_we",    {63'd0, dbg_we}, 64'd0);
      check("rst_addr",  {50'd0, dbg_addr}, 64'd0);
      check("rst_wdata", {32'd0, dbg_wdata}, 64'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      go_rti();
      do_dr("idcode", 32, {32'd0, $urandom});

      do_ir("ir_cap_byp", 4'b1111);
      do_dr("bypass_1011", 4, 64'hB);
      do_ir("ir_cap_5", 4'b0101);
      do_dr("bypass_other", 8, {56'd0, 8'($urandom)});

      do_ir("ir_cap_addr", 4'b0010);
      do_dr("addr_w", ADDR_W, 64'h0010);
      do_ir("ir_cap_data", 4'b0011);
      do_dr("data_w", DATA_W + 1, {31'd0, 1'b1, 32'hDEAD_BEEF});
      bus_ack($urandom_range(2, 8), $urandom);
      do_ir("ir_cap_addr2", 4'b0010);
      do_dr("addr_rb", ADDR_W, 64'h0011);

      do_ir("ir_cap_data2", 4'b0011);
      do_dr("rd_issue", DATA_W + 1, {31'd0, 1'b0, $urandom});
      bus_ack(7, 32'hCAFE_F00D);
      do_dr("rd_cap", DATA_W + 1, {31'd0, 1'b1, $urandom});
      do_dr("busy_cap", DATA_W + 1, {31'd0, 1'b0, $urandom});
      do_ir("ir_cap_addr3", 4'b0010);
      do_dr("addr_busy", ADDR_W, {50'd0, 14'($urandom)});
      bus_ack($urandom_range(1, 6), $urandom);

      do_ir("ir_cap_data3", 4'b0011);
      do_dr("pre_trst", DATA_W + 1, {31'd0, 1'b1, $urandom});
      trst = 1'b1;
      repeat (6) @(negedge clk);
      trst = 1'b0;
      repeat (6) @(negedge clk);
      m_ir = 4'b0001;
      check("trst_req_held", {63'd0, dbg_req}, 64'd1);
      tck_cycle(1'b0, 1'b0, t);
      do_dr("trst_idcode", 32, {32'd0, $urandom});
      bus_ack($urandom_range(1, 6), $urandom);

      for (int k = 0; k < 10; k++) begin
         case ($urandom_range(0, 3))
            0: begin
               do_ir("rnd_ir_addr", 4'b0010);
               do_dr("rnd_addr", ADDR_W, {50'd0, 14'($urandom)});
            end
            1: begin
               do_ir("rnd_ir_data", 4'b0011);
               r32 = $urandom;
               do_dr("rnd_data", DATA_W + 1, {31'd0, 1'($urandom), r32});
               if (m_busy && $urandom_range(0, 1) == 1) bus_ack($urandom_range(1, 9), $urandom);
            end
            2: begin
               do_ir("rnd_ir_byp", 4'($urandom_range(4, 14)));
               do_dr("rnd_byp", $urandom_range(2, 12), {32'd0, $urandom});
            end
            default: begin
               do_ir("rnd_ir_id", 4'b0001);
               do_dr("rnd_id", 32, {32'd0, $urandom});
            end
         endcase
      end
      if (m_busy) bus_ack($urandom_range(1, 5), $urandom);
      do_ir("end_ir_data", 4'b0011);
      do_dr("end_data", DATA_W + 1, {31'd0, 1'b1, $urandom});
      bus_ack(3, $urandom);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
